// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the EX-stage divider.
//   DIV_W       - default divider operand/result width
//   DIV_LAT     - cycles from operand accept to out_valid for a non-zero divisor
//   div_state_e - divider FSM state encoding
package cpu_pkg;

    localparam int DIV_W   = 32;
    localparam int DIV_LAT = DIV_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/cla_sub.sv
// cla_sub: combinational W-bit subtractor computing a + ~b + 1.
// Carries inside each 4-bit group come from generate/propagate lookahead.
// Group carries are chained between groups.
//   a, b     - minuend and subtrahend
//   diff     - a - b (modulo 2^W)
//   borrow_n - carry-out; 1 means no borrow (a >= b unsigned)
module cla_sub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_n
);

    localparam int NG = W / 4;

    logic [W-1:0] g_s;
    logic [W-1:0] p_s;

    assign g_s = a & ~b;
    assign p_s = a ^ ~b;

    // per-group lookahead carries, group carry chained into the next group
    always_comb begin
        logic [3:0] g4;
        logic [3:0] p4;
        logic [3:0] c4;
        logic       gg;
        logic       gp;
        logic       carry;
        g4    = 4'd0;
        p4    = 4'd0;
        c4    = 4'd0;
        gg    = 1'b0;
        gp    = 1'b0;
        carry = 1'b1;
        diff  = '0;
        for (int k = 0; k < NG; k++) begin
            g4    = g_s[4*k +: 4];
            p4    = p_s[4*k +: 4];
            c4[0] = carry;
            c4[1] = g4[0] | (p4[0] & carry);
            c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & carry);
            c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                  | (p4[2] & p4[1] & p4[0] & carry);
            gg    = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]);
            gp    = &p4;
            diff[4*k +: 4] = p4 ^ c4;
            carry = gg | (gp & carry);
        end
        borrow_n = carry;
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider (DIV / DIVU), one quotient bit per cycle.
//   in_valid/in_ready   - operand handshake (in_ready high only in IDLE)
//   is_signed           - 1 = two's complement, 0 = unsigned
//   dividend, divisor   - operands
//   flush               - aborts any operation, discards a pending result
//   out_valid/out_ready - result handshake
//   quotient, remainder - results (to LO / HI)
//   div_by_zero         - divisor was zero, valid with out_valid
//   busy                - high in CALC or FIX, stalls the pipeline
module div_seq
    import cpu_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    div_state_e state_q, state_d;
    // a_q holds the dividend magnitude; quotient bits shift in from the bottom
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sq_q, sq_d, sr_q, sr_d;
    logic out_valid_q, out_valid_d;
    logic dbz_q, dbz_d;
    logic in_ready_q, in_ready_d;
    logic busy_q, busy_d;

    logic [W-1:0] shift_s;
    logic [W-1:0] sub0_a_s, sub0_b_s, sub0_diff_s;
    logic [W-1:0] sub1_b_s, sub1_diff_s;
    logic         sub0_borrow_n_s;
    logic         sub1_borrow_unused_s;
    logic         neg_a_s, neg_b_s;

    assign shift_s = {r_q[W-2:0], a_q[W-1]};
    assign neg_a_s = is_signed & dividend[W-1];
    assign neg_b_s = is_signed & divisor[W-1];

    // Shared subtractor: |dividend| in IDLE, trial subtraction in CALC,
    // quotient negation in FIX. The second one negates divisor/remainder.
    always_comb begin
        sub0_a_s = '0;
        sub0_b_s = '0;
        case (state_q)
            IDLE:    sub0_b_s = dividend;
            CALC: begin
                sub0_a_s = shift_s;
                sub0_b_s = b_q;
            end
            FIX:     sub0_b_s = a_q;
            default: sub0_b_s = '0;
        endcase
        if (state_q == IDLE) begin
            sub1_b_s = divisor;
        end else begin
            sub1_b_s = r_q;
        end
    end

    cla_sub #(.W(W)) u_sub0 (
        .a        (sub0_a_s),
        .b        (sub0_b_s),
        .diff     (sub0_diff_s),
        .borrow_n (sub0_borrow_n_s)
    );

    cla_sub #(.W(W)) u_sub1 (
        .a        ('0),
        .b        (sub1_b_s),
        .diff     (sub1_diff_s),
        .borrow_n (sub1_borrow_unused_s)
    );

    // FSM next state and datapath updates; flush overrides everything
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        sq_d        = sq_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quot_d      = '1;
                            rem_d       = dividend;
                            dbz_d       = 1'b1;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            a_d     = neg_a_s ? sub0_diff_s : dividend;
                            b_d     = neg_b_s ? sub1_diff_s : divisor;
                            sq_d    = neg_a_s ^ neg_b_s;
                            sr_d    = neg_a_s;
                            r_d     = '0;
                            cnt_d   = CNT_LAST;
                            dbz_d   = 1'b0;
                            state_d = CALC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    // a set MSB shifted out means the W+1-bit value exceeds b_q
                    if (r_q[W-1] | sub0_borrow_n_s) begin
                        r_d = sub0_diff_s;
                        a_d = {a_q[W-2:0], 1'b1};
                    end else begin
                        r_d = shift_s;
                        a_d = {a_q[W-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    quot_d      = sq_q ? sub0_diff_s : a_q;
                    rem_d       = sr_q ? sub1_diff_s : r_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == CALC) || (state_d == FIX);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sq_q        <= 1'b0;
            sr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            sq_q        <= sq_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed + randomized check of div_seq against an arithmetic
// reference model (64-bit signed / unsigned division with truncation).
module tb_div_seq;
    import cpu_pkg::*;

    localparam int W = DIV_W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int n_checks;
    int n_fail;

    div_seq #(.W(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: truncating division, div-by-zero returns all ones / dividend
    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa;
        longint sb;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // issue one operation at a negedge, measure latency/busy, hold result, release
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           k;
        int           busy_cnt;
        int           wait_n;
        model(sgn, a, b, eq, er, edz);
        wait_n = 0;
        while (!in_ready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("in_ready_before_issue", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        in_valid  = 1'b0;
        is_signed = 1'($urandom_range(0, 1));
        dividend  = $urandom;
        divisor   = $urandom;
        k = 1;
        busy_cnt = 0;
        while (!out_valid && k < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        check_eq("latency", 64'(k), edz ? 64'd1 : 64'(DIV_LAT));
        check_eq("busy_cycles", 64'(busy_cnt), edz ? 64'd0 : 64'(DIV_LAT - 1));
        check_eq("busy_in_done", 64'(busy), 64'd0);
        check_eq("quotient", 64'(quotient), 64'(eq));
        check_eq("remainder", 64'(remainder), 64'(er));
        check_eq("div_by_zero", 64'(div_by_zero), 64'(edz));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_out_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("hold_quotient", 64'(quotient), 64'(eq));
            check_eq("hold_remainder", 64'(remainder), 64'(er));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("release_out_valid", 64'(out_valid), 64'd0);
        check_eq("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    // start an unsigned op and advance to the middle of CALC (cycle 10)
    task automatic start_and_advance(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = 1'b1;
        is_signed = 1'b0;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("mid_calc_busy", 64'(busy), 64'd1);
    endtask

    initial begin
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;
        int           wait_n;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_quotient", 64'(quotient), 64'd0);
        check_eq("rst_remainder", 64'(remainder), 64'd0);
        check_eq("rst_div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_op(1'b0, 32'd100, 32'd7, 5);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(1'b0, 32'h0000_1234, 32'd0, 2);
        run_op(1'b1, 32'h8000_0000, 32'd0, 0);

        // flush mid-CALC, then an immediate new operation
        start_and_advance(32'hFFFF_FFFF, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_in_ready", 64'(in_ready), 64'd1);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 0);

        // flush wins over in_valid in IDLE (a zero divisor would complete next cycle)
        in_valid = 1'b1;
        divisor  = '0;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush_vs_in_valid", 64'(out_valid), 64'd0);
        check_eq("flush_vs_in_valid_ready", 64'(in_ready), 64'd1);

        // flush discards a pending result in DONE
        in_valid  = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        wait_n = 0;
        while (!out_valid && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("done_before_flush", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_done_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_done_in_ready", 64'(in_ready), 64'd1);

        // asynchronous reset mid-CALC after a prior non-zero result
        run_op(1'b0, 32'd9, 32'd3, 0);
        start_and_advance(32'd12345, 32'd7);
        rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_quotient", 64'(quotient), 64'd0);
        check_eq("arst_remainder", 64'(remainder), 64'd0);
        check_eq("arst_div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_no_result", 64'(out_valid), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 0);

        // randomized operations with corner-biased divisors
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = '1;
                3:       b = 32'($urandom_range(1, 15));
                4:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(sgn, a, b, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle restoring integer divider for the CPU's EX stage. Handles MIPS-style DIV and DIVU, the inverse of the carry-lookahead adder path.
- One quotient bit is produced per cycle. Each trial subtraction uses a 32-bit subtractor built from 4-bit lookahead groups.
- Results go to the HI/LO write-back logic through a valid/ready handshake.
- The pipeline stalls while the divider is busy.

Parameters:
- W, 32, operand and result width (must be a multiple of 4).
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > W).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  divider can accept a new operation (high only in IDLE).
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  W  numerator.
- divisor  input  W  denominator.
- flush  input  1  pipeline flush; aborts any operation in progress.
- out_valid  output  1  quotient and remainder are valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  W  to LO.
- remainder  output  W  to HI.
- div_by_zero  output  1  divisor was zero; valid with out_valid.
- busy  output  1  high in CALC or FIX (stall request).

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On in_valid & in_ready, latch the operands. For signed operations, latch the magnitudes and the signs sq=sign(a)^sign(b) and sr=sign(a).
  - Divisor==0: go to DONE next cycle with quotient=all ones, remainder=dividend (unmodified), div_by_zero=1.
  - Otherwise: clear the partial remainder, load counter=W-1, go to CALC.
- CALC, one cycle per bit, MSB first:
  - Shift the next dividend bit into the partial remainder r and compute t = {r,bit} - divisor.
  - No borrow: r=t, q bit=1. Borrow: keep the shifted r, q bit=0.
  - When counter==0, go to FIX; otherwise decrement the counter.
- FIX:
  - Signed: negate the quotient if sq, negate the remainder if sr.
  - Unsigned: pass through unchanged.
  - Register the results and go to DONE.
- DONE:
  - out_valid=1. Outputs hold stable until out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
- Latency: accept at cycle 0 gives out_valid at cycle W+2 (34 for W=32). Divide-by-zero gives out_valid at cycle 1.
- Throughput: at most one operation per W+3 cycles. No new operation is accepted in the cycle out_valid drops.
- Overflow, signed -2^(W-1) / -1: quotient=0x80000000, remainder=0, div_by_zero=0. This falls out of the magnitude algorithm with no special case.
- Remainder sign: always equals the dividend sign (truncating division). |remainder| < |divisor|.
- flush:
  - Flush in any state: state=IDLE and out_valid=0 next cycle. A pending result is discarded.
  - Flush has priority over in_valid and out_ready in the same cycle. A new operation is not accepted in a cycle where flush=1.
- Mid-operation rst_n assertion: immediate return to reset values. No partial result ever appears on out_valid.
- in_valid while busy is ignored. Operands must be re-presented once in_ready is high.

Decomposition:
- Shared package cpu_pkg:
  - State encoding typedef (IDLE=0, CALC=1, FIX=2, DONE=3).
  - Constant DIV_W=32.
  - Constant DIV_LAT=W+2.
- Sub-module cla_sub:
  - Combinational W-bit subtractor a + ~b + 1, built from 4-bit group generate/propagate lookahead units.
  - Outputs diff and borrow_n (the carry-out).
  - Reused for the FIX-state negations (0 - x).

Test Plan:
- DIVU 100 / 7: accept at cycle 0 -> out_valid at cycle 34, quotient=14, remainder=2, div_by_zero=0. busy high on cycles 1-33.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Then DIV 7 / -2 -> quotient=-3, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- DIVU 0x1234 / 0 -> out_valid at cycle 1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0. Assert out_ready -> in_ready=1 next cycle.
- Assert flush at cycle 10 of a CALC -> IDLE next cycle with no out_valid. Immediately issue DIVU 9/3 -> quotient=3, remainder=0. Repeat with rst_n pulsed low mid-CALC -> all outputs return to reset values.
